bcd_counter: RTL and testbench

// - 4-digit decimal (BCD) counter, 0000..9999, advancing one count every clock.
// - Exposes the packed BCD value, each digit separately, and per-digit

---
 rtl/bcd_counter.sv | 57 +++++
 tb/tb_bcd_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bcd_counter.sv
// Four-digit free-running BCD counter (0000..9999) with per-digit carry enables.
// Optional `wrap` output (high while at 9999) when BCD_WRAP_FLAG_EN is defined.
module bcd_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [3:1]  ena,
    output logic [15:0] q,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
`ifdef BCD_WRAP_FLAG_EN
    output logic        wrap,
`endif
    output logic [3:0]  digit3
);

    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;

    // Only the value 9 wraps, so each digit can never leave 0..9 once reset.
    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_comb begin
        ena[1] = (d0 == 4'd9);
        ena[2] = ena[1] & (d1 == 4'd9);
        ena[3] = ena[2] & (d2 == 4'd9);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
            d2 <= 4'd0;
            d3 <= 4'd0;
        end else begin
            d0 <= next_digit(d0);
            if (ena[1]) d1 <= next_digit(d1);
            if (ena[2]) d2 <= next_digit(d2);
            if (ena[3]) d3 <= next_digit(d3);
        end
    end

    assign digit0 = d0;
    assign digit1 = d1;
    assign digit2 = d2;
    assign digit3 = d3;
    assign q      = {d3, d2, d1, d0};

`ifdef BCD_WRAP_FLAG_EN
    assign wrap = ena[3] & (d3 == 4'd9);
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed vector table, corner sequences,
// and randomized resets checked against an integer reference count.
module tb_bcd_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:1]  ena;
    logic [15:0] q;
    logic [3:0]  digit0, digit1, digit2, digit3;
`ifdef BCD_WRAP_FLAG_EN
    logic        wrap;
`endif

    bcd_counter dut (
        .clk    (clk),
        .reset  (reset),
        .ena    (ena),
        .q      (q),
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
`ifdef BCD_WRAP_FLAG_EN
        .wrap   (wrap),
`endif
        .digit3 (digit3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    typedef struct {
        logic        rst;
        int          edges;
        logic [15:0] exp_q;
        logic [2:0]  exp_ena;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference: plain integer count, reset to zero, modulo 10000.
    task automatic step();
        @(posedge clk);
        if (reset) model = 0;
        else       model = (model + 1) % 10000;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [2:0] e;
        e = {model % 1000 == 999, model % 100 == 99, model % 10 == 9};
        chk({tag, " q"}, q, to_bcd(model));
        chk({tag, " ena"}, ena, e);
        chk({tag, " digits"}, {digit3, digit2, digit1, digit0}, to_bcd(model));
        chk({tag, " range"}, (digit0 <= 9) && (digit1 <= 9) && (digit2 <= 9) && (digit3 <= 9), 1);
`ifdef BCD_WRAP_FLAG_EN
        chk({tag, " wrap"}, wrap, model == 9999);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 3,    16'h0000, 3'b000};
        vecs[1] = '{1'b0, 9,    16'h0009, 3'b001};
        vecs[2] = '{1'b0, 1,    16'h0010, 3'b000};
        vecs[3] = '{1'b0, 89,   16'h0099, 3'b011};
        vecs[4] = '{1'b0, 1,    16'h0100, 3'b000};
        vecs[5] = '{1'b0, 899,  16'h0999, 3'b111};
        vecs[6] = '{1'b0, 1,    16'h1000, 3'b000};
        vecs[7] = '{1'b0, 8999, 16'h9999, 3'b111};
        vecs[8] = '{1'b0, 1,    16'h0000, 3'b000};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst;
            for (int n = 0; n < vecs[i].edges; n++) begin
                step();
                check_model("run");
            end
            chk($sformatf("vec%0d q", i), q, vecs[i].exp_q);
            chk($sformatf("vec%0d ena", i), ena, vecs[i].exp_ena);
`ifdef BCD_WRAP_FLAG_EN
            chk($sformatf("vec%0d wrap", i), wrap, vecs[i].exp_q == 16'h9999);
`endif
        end

        // Mid-count reset at 0457.
        reset = 1'b0;
        repeat (457) step();
        chk("mid q before reset", q, 16'h0457);
        reset = 1'b1;
        step();
        chk("mid reset q", q, 16'h0000);
        chk("mid reset ena", ena, 3'b000);
        reset = 1'b0;
        step();
        chk("mid release q", q, 16'h0001);

        // Random reset pulses against the reference count.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) < 3);
            step();
            check_model("rand");
        end

        // Full 10000-count cycle back to zero.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step();
            check_model("full");
        end
        chk("full cycle q", q, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
